// File: rtl/exec_pkg.sv
// Shared types for the execute stage: ALU operation codes and FSM states.
package exec_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } op_t;

    typedef enum logic {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } state_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial product per step, W steps total.
// product is the accumulator value after the current step (valid with last).
module mul_iter
    import exec_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] product,
    output logic           last
);
    localparam int CW = $clog2(W);

    logic [2*W-1:0] acc;
    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  count;

    // Multiplicand walks left while the multiplier walks right, so bit 0
    // of the multiplier always selects the current partial product.
    assign product = acc + (mplier[0] ? mcand : '0);
    assign last    = (count == CW'(W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{W{1'b0}}, a};
            mplier <= b;
            count  <= '0;
        end else if (step) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
        end
    end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU plus iterative MUL, driving the register
// file write port and the zero/carry flags of the last written result.
module exec_stage
    import exec_pkg::*;
#(
    parameter int W = 8,
    parameter int D = 3
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         Start,
    input  op_t          Op,
    input  logic [W-1:0] Src_0_data,
    input  logic [W-1:0] Src_1_data,
    input  logic [D-1:0] Dest_address,
    output logic         Busy,
    output logic         Reg_write_en,
    output logic [D-1:0] Reg_write_address,
    output logic [W-1:0] Reg_write_data,
    output logic         Zero_flag,
    output logic         Carry_flag,
    output state_t       fsm_state
);
    localparam int SW = $clog2(W);

    // Handshake: Start is a valid; Busy is an inverted ready. A request is
    // taken on the rising edge where Start=1 and Busy=0; otherwise dropped.

    state_t         state, next_state;
    logic           mul_load, mul_step, wb_alu, wb_mul, mul_last;
    logic [2*W-1:0] mul_product;
    logic [D-1:0]   mul_dest;
    logic [W:0]     alu_wide;
    logic [W-1:0]   alu_res, wb_data;
    logic           alu_carry, wb_carry;
    logic [SW-1:0]  shamt;

    assign shamt     = Src_1_data[SW-1:0];
    assign Busy      = (state == MUL_RUN);
    assign fsm_state = state;

    // Wide intermediate carries the bit shifted or carried out of the word.
    always_comb begin
        alu_wide  = '0;
        alu_res   = '0;
        alu_carry = 1'b0;
        case (Op)
            OP_ADD: begin
                alu_wide  = {1'b0, Src_0_data} + {1'b0, Src_1_data};
                alu_res   = alu_wide[W-1:0];
                alu_carry = alu_wide[W];
            end
            OP_SUB: begin
                alu_wide  = {1'b0, Src_0_data} - {1'b0, Src_1_data};
                alu_res   = alu_wide[W-1:0];
                alu_carry = alu_wide[W];
            end
            OP_AND: alu_res = Src_0_data & Src_1_data;
            OP_OR:  alu_res = Src_0_data | Src_1_data;
            OP_XOR: alu_res = Src_0_data ^ Src_1_data;
            OP_SHL: begin
                alu_wide  = {1'b0, Src_0_data} << shamt;
                alu_res   = alu_wide[W-1:0];
                alu_carry = alu_wide[W];
            end
            OP_SHR: begin
                alu_wide  = {Src_0_data, 1'b0} >> shamt;
                alu_res   = alu_wide[W:1];
                alu_carry = alu_wide[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        next_state = state;
        mul_load   = 1'b0;
        mul_step   = 1'b0;
        wb_alu     = 1'b0;
        wb_mul     = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    if (Op == OP_MUL) begin
                        mul_load   = 1'b1;
                        next_state = MUL_RUN;
                    end else begin
                        wb_alu = 1'b1;
                    end
                end
            end
            MUL_RUN: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    wb_mul     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= next_state;
    end

    mul_iter #(.W(W)) u_mul (
        .clk     (CLK),
        .rst     (Reset),
        .load    (mul_load),
        .step    (mul_step),
        .a       (Src_0_data),
        .b       (Src_1_data),
        .product (mul_product),
        .last    (mul_last)
    );

    assign wb_data  = wb_mul ? mul_product[W-1:0] : alu_res;
    assign wb_carry = wb_mul ? (|mul_product[2*W-1:W]) : alu_carry;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            mul_dest          <= '0;
            Reg_write_en      <= 1'b0;
            Reg_write_address <= '0;
            Reg_write_data    <= '0;
            Zero_flag         <= 1'b0;
            Carry_flag        <= 1'b0;
        end else begin
            Reg_write_en <= wb_alu | wb_mul;
            if (mul_load) mul_dest <= Dest_address;
            if (wb_alu | wb_mul) begin
                Reg_write_address <= wb_mul ? mul_dest : Dest_address;
                Reg_write_data    <= wb_data;
                Zero_flag         <= (wb_data == '0);
                Carry_flag        <= wb_carry;
            end
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
// Randomized scoreboard bench for exec_stage against an arithmetic reference model.
module tb_exec_stage;
    import exec_pkg::*;

    localparam int W = 8;
    localparam int D = 3;

    typedef struct {
        int           due;
        logic [D-1:0] addr;
        logic [W-1:0] data;
        logic         zero;
        logic         carry;
    } exp_t;

    logic         CLK = 1'b0;
    logic         Reset = 1'b1;
    logic         Start = 1'b0;
    op_t          Op = OP_ADD;
    logic [W-1:0] Src_0_data = '0;
    logic [W-1:0] Src_1_data = '0;
    logic [D-1:0] Dest_address = '0;
    logic         Busy;
    logic         Reg_write_en;
    logic [D-1:0] Reg_write_address;
    logic [W-1:0] Reg_write_data;
    logic         Zero_flag;
    logic         Carry_flag;
    state_t       fsm_state;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];

    exec_stage #(.W(W), .D(D)) dut (
        .CLK               (CLK),
        .Reset             (Reset),
        .Start             (Start),
        .Op                (Op),
        .Src_0_data        (Src_0_data),
        .Src_1_data        (Src_1_data),
        .Dest_address      (Dest_address),
        .Busy              (Busy),
        .Reg_write_en      (Reg_write_en),
        .Reg_write_address (Reg_write_address),
        .Reg_write_data    (Reg_write_data),
        .Zero_flag         (Zero_flag),
        .Carry_flag        (Carry_flag),
        .fsm_state         (fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic exp_t ref_model(op_t op, int a, int b, int d, int due);
        exp_t e;
        int   r;
        int   c;
        int   amt;
        amt = b % W;
        r   = 0;
        c   = 0;
        case (op)
            OP_ADD: begin r = a + b; c = (r >= (1 << W)) ? 1 : 0; end
            OP_SUB: begin r = a - b; c = (a < b) ? 1 : 0; end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_SHL: begin
                r = a << amt;
                c = (amt == 0) ? 0 : ((a >> (W - amt)) & 1);
            end
            OP_SHR: begin
                r = a >> amt;
                c = (amt == 0) ? 0 : ((a >> (amt - 1)) & 1);
            end
            OP_MUL: begin r = a * b; c = ((r >> W) != 0) ? 1 : 0; end
            default: ;
        endcase
        e.due   = due;
        e.addr  = D'(d);
        e.data  = r[W-1:0];
        e.zero  = (r[W-1:0] == '0);
        e.carry = (c != 0);
        return e;
    endfunction

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- driver tasks (called on a negedge) ----------------
    task automatic randomize_src();
        Src_0_data   = W'($urandom_range(0, (1 << W) - 1));
        Src_1_data   = W'($urandom_range(0, (1 << W) - 1));
        Dest_address = D'($urandom_range(0, (1 << D) - 1));
    endtask

    task automatic issue(op_t op, int a, int b, int d, bit expect_wb);
        int n;
        n = 0;
        while (Busy && n < 50) begin
            randomize_src();
            @(negedge CLK);
            n++;
        end
        if (Busy) check("issue_busy_timeout", 1, 0);
        Start        = 1'b1;
        Op           = op;
        Src_0_data   = W'(a);
        Src_1_data   = W'(b);
        Dest_address = D'(d);
        if (expect_wb)
            exp_q.push_back(ref_model(op, a, b, d, cyc + ((op == OP_MUL) ? W + 1 : 1)));
        @(negedge CLK);
        Start = 1'b0;
        randomize_src();
    endtask

    // Counts Busy cycles of a just-accepted MUL while hammering Start with
    // ADDs that must be ignored; Start is dropped before returning.
    task automatic mul_busy_window(output int n);
        n = 0;
        while (Busy && n < 40) begin
            n++;
            Start = 1'b1;
            Op    = OP_ADD;
            randomize_src();
            @(negedge CLK);
        end
        Start = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t         e;
        logic [D-1:0] last_addr;
        logic [W-1:0] last_data;
        logic         last_zero, last_carry;
        last_addr  = '0;
        last_data  = '0;
        last_zero  = 1'b0;
        last_carry = 1'b0;
        forever begin
            @(negedge CLK);
            if (Reset) begin
                last_addr  = '0;
                last_data  = '0;
                last_zero  = 1'b0;
                last_carry = 1'b0;
            end else if (Reg_write_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_cycle", cyc, e.due);
                    check("wb_addr", int'(Reg_write_address), int'(e.addr));
                    check("wb_data", int'(Reg_write_data), int'(e.data));
                    check("wb_zero", int'(Zero_flag), int'(e.zero));
                    check("wb_carry", int'(Carry_flag), int'(e.carry));
                    last_addr  = e.addr;
                    last_data  = e.data;
                    last_zero  = e.zero;
                    last_carry = e.carry;
                end
            end else begin
                check("hold_addr", int'(Reg_write_address), int'(last_addr));
                check("hold_data", int'(Reg_write_data), int'(last_data));
                check("hold_zero", int'(Zero_flag), int'(last_zero));
                check("hold_carry", int'(Carry_flag), int'(last_carry));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int a, b;
        op_t op;

        repeat (3) @(negedge CLK);
        Reset = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            check("idle_no_write", int'(Reg_write_en), 0);
            check("idle_busy", int'(Busy), 0);
        end

        issue(OP_ADD, 200, 100, 3, 1);
        issue(OP_SUB, 5, 5, 1, 1);
        issue(OP_SUB, 3, 4, 2, 1);
        issue(OP_SHL, 8'h81, 1, 4, 1);
        issue(OP_SHR, 8'h01, 1, 0, 1);
        issue(OP_SHL, 8'h5a, 0, 6, 1);
        issue(OP_SHR, 8'hf0, 9, 7, 1);
        issue(OP_XOR, 8'hff, 8'hff, 1, 1);

        issue(OP_MUL, 15, 17, 5, 1);
        mul_busy_window(n);
        check("mul_busy_len", n, W);
        issue(OP_ADD, 7, 9, 2, 1);

        issue(OP_MUL, 16, 16, 6, 1);
        mul_busy_window(n);
        check("mul_busy_len2", n, W);
        for (int i = 0; i < 4; i++) issue(OP_ADD, 10 * i, 250, i, 1);

        issue(OP_MUL, 200, 3, 4, 0);
        repeat (4) @(negedge CLK);
        #2 Reset = 1'b1;
        #1;
        check("abort_busy", int'(Busy), 0);
        check("abort_wen", int'(Reg_write_en), 0);
        check("abort_zero", int'(Zero_flag), 0);
        check("abort_carry", int'(Carry_flag), 0);
        check("abort_data", int'(Reg_write_data), 0);
        @(negedge CLK);
        #2 Reset = 1'b0;
        @(negedge CLK);
        issue(OP_ADD, 1, 1, 1, 1);

        repeat (80) begin
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            op = op_t'($urandom_range(0, 7));
            a  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 255);
            b  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 255);
            issue(op, a, b, $urandom_range(0, 7), 1);
        end

        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("queue_drain", exp_q.size(), 0);
        repeat (2) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
